// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable full/empty thresholds and selectable
// first-word-fall-through or registered one-cycle-latency read port.
module sync_fifo_prog #(
    parameter int DWIDTH            = 32,
    parameter int DEPTH             = 512,
    parameter int FWFT              = 1,
    parameter int PROG_FULL_THRESH  = 508,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     wr_full,
    output logic                     wr_almost_full,
    output logic                     wr_prog_full,
    output logic                     rd_empty,
    output logic                     rd_almost_empty,
    output logic                     rd_prog_empty,
    output logic                     wr_overflow,
    output logic                     rd_underflow,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C    = PW'(DEPTH);
    localparam logic [PW-1:0] DEPTH_M1_C = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PFULL_C    = PW'(PROG_FULL_THRESH);
    localparam logic [PW-1:0] PEMPTY_C   = PW'(PROG_EMPTY_THRESH);
    localparam logic [PW-1:0] ONE_C      = PW'(1);
    localparam logic [PW-1:0] TWO_C      = PW'(2);
    localparam logic [PW-1:0] ZERO_C     = '0;

    if (DWIDTH < 1) begin : g_bad_dwidth
        $error("sync_fifo_prog: DWIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_prog: DEPTH must be a power of two >= 4");
    end
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1) begin : g_bad_pfull
        $error("sync_fifo_prog: PROG_FULL_THRESH out of range 1..DEPTH-1");
    end
    if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pempty
        $error("sync_fifo_prog: PROG_EMPTY_THRESH out of range 1..DEPTH-1");
    end

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    // FWFT: head word is presented on rd_data; standard: pop strobe
    logic              rd_valid_q, rd_valid_d;
    logic              wr_overflow_q, wr_overflow_d;
    logic              rd_underflow_q, rd_underflow_d;

    logic              wr_accept;
    logic              rd_accept;
    logic              load_head;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        wr_full         = (cnt_q == DEPTH_C);
        wr_almost_full  = (cnt_q >= DEPTH_M1_C);
        wr_prog_full    = (cnt_q >= PFULL_C);
        rd_almost_empty = (cnt_q <= ONE_C);
        rd_prog_empty   = (cnt_q <= PEMPTY_C);
        if (FWFT != 0) begin
            rd_empty = ~rd_valid_q;
        end else begin
            rd_empty = (cnt_q == ZERO_C);
        end
        rd_valid     = rd_valid_q;
        rd_data      = rd_data_q;
        fifo_cnt     = cnt_q;
        wr_overflow  = wr_overflow_q;
        rd_underflow = rd_underflow_q;
    end

    always_comb begin
        wr_accept = wr_en & ~wr_full;
        rd_accept = rd_en & ~rd_empty;
        wr_ptr_d  = wr_ptr_q + {{(PW-1){1'b0}}, wr_accept};
        rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, rd_accept};
        // Count includes the word held in the output register in FWFT mode,
        // because that word still occupies its memory slot until popped.
        cnt_d     = wr_ptr_d - rd_ptr_d;

        if (FWFT != 0) begin
            rd_addr    = rd_ptr_d[AW-1:0];
            load_head  = rd_accept ? (cnt_q >= TWO_C)
                                   : (~rd_valid_q & (cnt_q != ZERO_C));
            rd_valid_d = rd_accept ? (cnt_q >= TWO_C)
                                   : (rd_valid_q | (cnt_q != ZERO_C));
        end else begin
            rd_addr    = rd_ptr_q[AW-1:0];
            load_head  = rd_accept;
            rd_valid_d = rd_accept;
        end

        // Loaded words were always written at an earlier edge: no bypass path.
        rd_data_d      = load_head ? mem_q[rd_addr] : rd_data_q;
        wr_overflow_d  = wr_en & wr_full;
        rd_underflow_d = rd_en & rd_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_overflow_q  <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            wr_overflow_q  <= wr_overflow_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives one stimulus stream into an FWFT and a standard-read instance and
// checks both against queue-based reference models.
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PF    = 6;
    localparam int PE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] rd_data [2];
    logic          rd_valid [2];
    logic          wr_full [2];
    logic          wr_almost_full [2];
    logic          wr_prog_full [2];
    logic          rd_empty [2];
    logic          rd_almost_empty [2];
    logic          rd_prog_empty [2];
    logic          wr_overflow [2];
    logic          rd_underflow [2];
    logic [3:0]    fifo_cnt [2];

    always #5 clk = ~clk;

    sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                     .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .wr_full(wr_full[0]), .wr_almost_full(wr_almost_full[0]), .wr_prog_full(wr_prog_full[0]),
        .rd_empty(rd_empty[0]), .rd_almost_empty(rd_almost_empty[0]), .rd_prog_empty(rd_prog_empty[0]),
        .wr_overflow(wr_overflow[0]), .rd_underflow(rd_underflow[0]), .fifo_cnt(fifo_cnt[0])
    );

    sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                     .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)) u_dut_std (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .wr_full(wr_full[1]), .wr_almost_full(wr_almost_full[1]), .wr_prog_full(wr_prog_full[1]),
        .rd_empty(rd_empty[1]), .rd_almost_empty(rd_almost_empty[1]), .rd_prog_empty(rd_prog_empty[1]),
        .wr_overflow(wr_overflow[1]), .rd_underflow(rd_underflow[1]), .fifo_cnt(fifo_cnt[1])
    );

    // Reference state: stored words in order, plus FWFT "head shown" flag
    // and the standard-mode last popped word.
    logic [DW-1:0] qf [$];
    logic [DW-1:0] qs [$];
    bit            shown;
    logic [DW-1:0] last_pop;

    int            e_cnt [2];
    bit            e_valid [2];
    bit            e_empty [2];
    bit            e_ovf [2];
    bit            e_udf [2];
    logic [DW-1:0] e_data [2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        qf.delete();
        qs.delete();
        shown    = 1'b0;
        last_pop = '0;
        for (int m = 0; m < 2; m++) begin
            e_cnt[m]   = 0;
            e_valid[m] = 1'b0;
            e_empty[m] = 1'b1;
            e_ovf[m]   = 1'b0;
            e_udf[m]   = 1'b0;
            e_data[m]  = '0;
        end
    endtask

    task automatic model_edge(input bit w, input bit r, input logic [DW-1:0] d);
        int  n;
        bit  full, emp, wa, ra;
        // FWFT: head appears one edge after it lands in an empty FIFO; a pop
        // shows the next word at once only if one was already stored.
        n    = qf.size();
        full = (n == DEPTH);
        emp  = !shown;
        wa   = w && !full;
        ra   = r && !emp;
        e_ovf[0] = w && full;
        e_udf[0] = r && emp;
        if (ra) void'(qf.pop_front());
        shown = ra ? (n >= 2) : (n >= 1);
        if (wa) qf.push_back(d);
        e_cnt[0]   = qf.size();
        e_valid[0] = shown;
        e_empty[0] = !shown;
        e_data[0]  = shown ? qf[0] : '0;

        n    = qs.size();
        full = (n == DEPTH);
        emp  = (n == 0);
        wa   = w && !full;
        ra   = r && !emp;
        e_ovf[1] = w && full;
        e_udf[1] = r && emp;
        if (ra) last_pop = qs.pop_front();
        if (wa) qs.push_back(d);
        e_cnt[1]   = qs.size();
        e_valid[1] = ra;
        e_empty[1] = (qs.size() == 0);
        e_data[1]  = last_pop;
    endtask

    task automatic compare_all(input bit all_data);
        string p;
        for (int m = 0; m < 2; m++) begin
            p = (m == 0) ? "fwft" : "std";
            chk({p, ".cnt"},      32'(fifo_cnt[m]),        32'(e_cnt[m]));
            chk({p, ".empty"},    32'(rd_empty[m]),        32'(e_empty[m]));
            chk({p, ".valid"},    32'(rd_valid[m]),        32'(e_valid[m]));
            chk({p, ".full"},     32'(wr_full[m]),         32'(e_cnt[m] == DEPTH));
            chk({p, ".afull"},    32'(wr_almost_full[m]),  32'(e_cnt[m] >= DEPTH - 1));
            chk({p, ".pfull"},    32'(wr_prog_full[m]),    32'(e_cnt[m] >= PF));
            chk({p, ".aempty"},   32'(rd_almost_empty[m]), 32'(e_cnt[m] <= 1));
            chk({p, ".pempty"},   32'(rd_prog_empty[m]),   32'(e_cnt[m] <= PE));
            chk({p, ".overflow"}, 32'(wr_overflow[m]),     32'(e_ovf[m]));
            chk({p, ".underflow"},32'(rd_underflow[m]),    32'(e_udf[m]));
            if (all_data || m == 1 || e_valid[m])
                chk({p, ".rd_data"}, 32'(rd_data[m]), 32'(e_data[m]));
        end
    endtask

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1;
        compare_all(1'b0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        model_reset();
        compare_all(1'b1);
        @(posedge clk);
        #1;
        compare_all(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int unsigned wp [6] = '{90, 30, 100, 70, 50, 95};
    int unsigned rp [6] = '{30, 90, 100, 70, 50, 60};

    initial begin
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        compare_all(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // single word latency into empty
        step(1'b1, 1'b0, 8'hA1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        // underflow on empty
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // fill, overflow, read+write while full, drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);

        // simultaneous read/write at mid level
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);

        // reset with five words stored, then reuse
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        mid_reset();
        step(1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, 99) < wp[ph], $urandom_range(0, 99) < rp[ph],
                     8'($urandom));
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
